mac_requant_collector: RTL and testbench
========================================

Name: mac_requant_collector

Overview:
- Downstream stage of the signed multiply-accumulate unit.
- Captures each completed accumulation (result and finish), adds a per-channel bias, applies rounding right-shift requantization, optional ReLU and saturation to DATA_WIDTH.
- Buffers the quantized values in a small FIFO with a valid/ready output, feeding the output-feature-map writer.

Parameters:
- ACC_WIDTH, 32, width of incoming signed accumulator (equals RESULT_SIZE).
- OUT_WIDTH, 8, width of signed quantized output (equals DATA_WIDTH).
- SHIFT_W, 5, width of requant shift amount.
- FIFO_DEPTH, 4, output FIFO entries (power of two, >=2).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- acc_result  in  ACC_WIDTH  signed accumulated sum from MAC.
- acc_finish  in  1  MAC finish flag; may be held high for more than one cycle.
- bias  in  ACC_WIDTH  signed bias added to the captured sum.
- shift  in  SHIFT_W  right-shift amount, 0..ACC_WIDTH-1.
- relu_en  in  1  clamp negatives to 0 when 1.
- out_data  out  OUT_WIDTH  signed quantized value at FIFO head.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts out_data this cycle.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- overflow  out  1  sticky: a result was dropped because the FIFO was full.

Behaviour:
- Reset:
  - Single clock; reset is synchronous and active-high.
  - rst high at a clock edge clears: pipeline valids, FIFO pointers, fifo_count=0, out_valid=0, out_data=0, overflow=0, finish-edge register=0.
  - Reset mid-operation discards all in-flight and buffered results.
- Capture:
  - Event = acc_finish high and finish_d low, where finish_d is acc_finish registered.
  - A level held high produces exactly one event.
  - acc_finish high in the first cycle after reset counts as an event.
  - On the event edge (cycle N), register acc_result, bias, shift and relu_en together.
  - Config is sampled per event, not tracked afterwards.
- Stage 1 (edge N+1):
  - sum = sext(acc_result) + sext(bias), ACC_WIDTH+1 bits, no wrap.
- Stage 2 (edge N+2):
  - If shift=0: q = sum.
  - Else: q = (sum + 2^(shift-1)) >>> shift, arithmetic shift.
  - Width ACC_WIDTH+2 so the rounding add cannot overflow.
  - Rounding is half toward +infinity.
- Stage 3 (edge N+3):
  - If relu_en and q<0: q = 0.
  - Saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - Write to FIFO.
- Latency:
  - Event at edge N gives out_valid=1 in the cycle after edge N+3 if the FIFO was empty. Latency is 3 cycles.
  - Throughput: one event per 2 cycles minimum, since acc_finish must drop between events. The pipeline accepts one per cycle.
- FIFO and handshake:
  - Pop when out_valid & out_ready; out_data is the registered head.
  - Order preserved.
  - Push while full with a simultaneous pop: accepted, count unchanged.
  - Push while full without a pop: result dropped, overflow set to 1 and held until rst.
  - Push and pop while empty: the write takes effect, pop ignored because out_valid=0.
  - out_data is held stable while out_valid & !out_ready.
  - Pointers wrap modulo FIFO_DEPTH.
  - fifo_count is exact every cycle.
- Stall:
  - The pipeline never stalls; backpressure is handled only by the FIFO and the overflow flag.
- States:
  - Per-stage valid bits: IDLE (no valids), FILLING (stage valids set), BUFFERED (FIFO non-empty).
  - No explicit FSM beyond the valid pipeline and FIFO counters.

Test Plan:
- Basic requant: acc=1000, bias=24, shift=4, relu_en=0, out_ready=1 -> out_data=64 (0x40), out_valid 1 cycle, latency 3 cycles from finish edge.
- Rounding:
  - acc=23, bias=0, shift=3 -> 3.
  - acc=-20, bias=0, shift=3 -> -2 (0xFE).
  - acc=-5, bias=0, shift=0 -> -5.
- Saturation and ReLU:
  - acc=-300, shift=0, relu_en=0 -> -128 (0x80).
  - Same with relu_en=1 -> 0.
  - acc=0x7FFFFFFF, bias=1, shift=0 -> 127, no wrap to negative.
- Backpressure: out_ready=0, five events with values 1..5 -> fifo_count=4, overflow=1; then out_ready=1 -> pops 1,2,3,4 in order, overflow stays 1.
- Finish level and full-with-pop:
  - acc_finish held high 10 cycles -> exactly one FIFO entry.
  - FIFO full with push coinciding with a pop -> count stays 4, overflow stays 0.
- Reset mid-operation: event at edge N, rst=1 at edge N+2 -> out_valid=0, fifo_count=0, overflow=0, no output ever appears for that event.

Source files
------------

// File: rtl/mac_requant_collector_if.sv
// Output stream bus of the requant collector: quantized value plus valid/ready.
// Handshake: a word transfers on a clock edge where out_valid && out_ready; out_data is stable while out_valid && !out_ready.
interface mac_requant_collector_if #(
  parameter int OUT_WIDTH = 8
);
  logic signed [OUT_WIDTH-1:0] out_data;
  logic                        out_valid;
  logic                        out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/mac_requant_collector.sv
// Captures finished MAC sums, adds bias, rounds/shifts, applies ReLU and saturation,
// and buffers the quantized values in a small FIFO toward the output-map writer.
module mac_requant_collector #(
  parameter int ACC_WIDTH  = 32,
  parameter int OUT_WIDTH  = 8,
  parameter int SHIFT_W    = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [ACC_WIDTH-1:0]  acc_result,
  input  logic                         acc_finish,
  input  logic signed [ACC_WIDTH-1:0]  bias,
  input  logic        [SHIFT_W-1:0]    shift,
  input  logic                         relu_en,
  mac_requant_collector_if.master      out_bus,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         overflow
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic signed [ACC_WIDTH+1:0] SAT_MAX = (ACC_WIDTH+2)'((2 ** (OUT_WIDTH-1)) - 1);
  localparam logic signed [ACC_WIDTH+1:0] SAT_MIN = -SAT_MAX - (ACC_WIDTH+2)'(1);

  logic                        finish_d;
  logic                        capture;

  logic                        v0, v1, v2;
  logic signed [ACC_WIDTH-1:0] r_acc, r_bias;
  logic        [SHIFT_W-1:0]   r_shift, s1_shift;
  logic                        r_relu, s1_relu, s2_relu;
  logic signed [ACC_WIDTH:0]   s1_sum;
  logic signed [ACC_WIDTH+1:0] s2_q;

  logic signed [ACC_WIDTH+1:0] sum_ext, rnd, q_next, q_relu;
  logic        [OUT_WIDTH-1:0] sat_val;

  logic [OUT_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic                 push, pop, full, accept;

  // A level held on acc_finish yields one event; finish_d resets low so a
  // high level right after reset still counts.
  assign capture = acc_finish & ~finish_d;

  always_comb begin
    sum_ext = {s1_sum[ACC_WIDTH], s1_sum};
    rnd     = (ACC_WIDTH+2)'(1) << (s1_shift - SHIFT_W'(1));
    q_next  = sum_ext;
    if (s1_shift != '0) q_next = (sum_ext + rnd) >>> s1_shift;
  end

  always_comb begin
    q_relu = s2_q;
    if (s2_relu && (s2_q < 0)) q_relu = '0;
    sat_val = q_relu[OUT_WIDTH-1:0];
    if (q_relu > SAT_MAX) sat_val = SAT_MAX[OUT_WIDTH-1:0];
    else if (q_relu < SAT_MIN) sat_val = SAT_MIN[OUT_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      finish_d <= 1'b0;
      v0       <= 1'b0;
      v1       <= 1'b0;
      v2       <= 1'b0;
      r_acc    <= '0;
      r_bias   <= '0;
      r_shift  <= '0;
      r_relu   <= 1'b0;
      s1_sum   <= '0;
      s1_shift <= '0;
      s1_relu  <= 1'b0;
      s2_q     <= '0;
      s2_relu  <= 1'b0;
    end else begin
      finish_d <= acc_finish;
      v0       <= capture;
      if (capture) begin
        r_acc   <= acc_result;
        r_bias  <= bias;
        r_shift <= shift;
        r_relu  <= relu_en;
      end
      v1       <= v0;
      s1_sum   <= {r_acc[ACC_WIDTH-1], r_acc} + {r_bias[ACC_WIDTH-1], r_bias};
      s1_shift <= r_shift;
      s1_relu  <= r_relu;
      v2       <= v1;
      s2_q     <= q_next;
      s2_relu  <= s1_relu;
    end
  end

  // The pipeline never stalls: a push into a full FIFO survives only if a pop frees a slot the same edge.
  assign push   = v2;
  assign pop    = out_bus.out_valid & out_bus.out_ready;
  assign full   = (fifo_count == (PTR_W+1)'(FIFO_DEPTH));
  assign accept = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= sat_val;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_count <= fifo_count + {{PTR_W{1'b0}}, accept} - {{PTR_W{1'b0}}, pop};
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  assign out_bus.out_data  = mem[rd_ptr];
  assign out_bus.out_valid = (fifo_count != '0);
endmodule

// File: tb/tb_mac_requant_collector.sv
// Directed bench for mac_requant_collector: expected words are queued at issue time
// and a negedge monitor compares every handshake against the queue head.
module tb_mac_requant_collector;
  logic               clk = 1'b0;
  logic               rst;
  logic signed [31:0] acc_result;
  logic               acc_finish;
  logic signed [31:0] bias;
  logic        [4:0]  shift;
  logic               relu_en;
  logic        [2:0]  fifo_count;
  logic               overflow;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];

  mac_requant_collector_if #(.OUT_WIDTH(8)) bus ();

  mac_requant_collector dut (
    .clk        (clk),
    .rst        (rst),
    .acc_result (acc_result),
    .acc_finish (acc_finish),
    .bias       (bias),
    .shift      (shift),
    .relu_en    (relu_en),
    .out_bus    (bus.master),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One finish pulse: edge N captures, finish drops for the following cycle.
  task automatic send(input logic signed [31:0] a, input logic signed [31:0] b,
                      input logic [4:0] s, input logic r, input bit exp_push, input logic [7:0] exp_v);
    acc_result = a;
    bias       = b;
    shift      = s;
    relu_en    = r;
    acc_finish = 1'b1;
    if (exp_push) exp_q.push_back(exp_v);
    tick();
    acc_finish = 1'b0;
    tick();
  endtask

  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: got 0x%0h, expected no output", bus.out_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (bus.out_data !== e) begin
          n_fail++;
          $display("FAIL out_data: got 0x%0h, expected 0x%0h", bus.out_data, e);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; acc_result = '0; acc_finish = 1'b0; bias = '0; shift = '0; relu_en = 1'b0;
    bus.out_ready = 1'b0;
    wait_cycles(3);
    rst = 1'b0;
    check("reset_valid", {31'd0, bus.out_valid}, 32'd0);
    check("reset_count", {29'd0, fifo_count}, 32'd0);
    check("reset_overflow", {31'd0, overflow}, 32'd0);
    check("reset_data", {24'd0, bus.out_data}, 32'd0);

    // Basic requant with latency probe: (1024 + 8) >>> 4 = 64.
    bus.out_ready = 1'b1;
    acc_result = 32'sd1000; bias = 32'sd24; shift = 5'd4; relu_en = 1'b0;
    acc_finish = 1'b1;
    exp_q.push_back(8'h40);
    tick();
    acc_finish = 1'b0;
    tick();
    tick();
    check("lat_n2_valid", {31'd0, bus.out_valid}, 32'd0);
    tick();
    check("lat_n3_valid", {31'd0, bus.out_valid}, 32'd1);
    check("lat_n3_data", {24'd0, bus.out_data}, 32'h40);
    tick();
    check("lat_n4_valid", {31'd0, bus.out_valid}, 32'd0);

    send(32'sd23,  32'sd0, 5'd3, 1'b0, 1'b1, 8'h03);
    send(-32'sd20, 32'sd0, 5'd3, 1'b0, 1'b1, 8'hFE);
    send(-32'sd12, 32'sd0, 5'd3, 1'b0, 1'b1, 8'hFF);
    send(-32'sd5,  32'sd0, 5'd0, 1'b0, 1'b1, 8'hFB);
    send(-32'sd300, 32'sd0, 5'd0, 1'b0, 1'b1, 8'h80);
    send(-32'sd300, 32'sd0, 5'd0, 1'b1, 1'b1, 8'h00);
    send(32'sh7FFFFFFF, 32'sd1, 5'd0, 1'b0, 1'b1, 8'h7F);
    send(32'sh7FFFFFFF, 32'sh7FFFFFFF, 5'd31, 1'b0, 1'b1, 8'h02);
    send(32'sh80000000, 32'sh80000000, 5'd31, 1'b0, 1'b1, 8'hFE);
    wait_cycles(6);
    check("vectors_drained", exp_q.size(), 32'd0);

    // Backpressure: five results into four slots, fifth dropped.
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 5; i++)
      send(32'(i), 32'sd0, 5'd0, 1'b0, (i <= 4), 8'(i));
    wait_cycles(5);
    check("bp_count", {29'd0, fifo_count}, 32'd4);
    check("bp_overflow", {31'd0, overflow}, 32'd1);
    bus.out_ready = 1'b1;
    wait_cycles(6);
    check("bp_drain_count", {29'd0, fifo_count}, 32'd0);
    check("bp_overflow_sticky", {31'd0, overflow}, 32'd1);
    check("bp_queue_empty", exp_q.size(), 32'd0);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_clears_overflow", {31'd0, overflow}, 32'd0);

    // Level-held finish gives exactly one entry.
    bus.out_ready = 1'b0;
    acc_result = 32'sd7; bias = 32'sd0; shift = 5'd0; relu_en = 1'b0;
    acc_finish = 1'b1;
    exp_q.push_back(8'h07);
    wait_cycles(10);
    acc_finish = 1'b0;
    wait_cycles(5);
    check("level_count", {29'd0, fifo_count}, 32'd1);

    for (int i = 8; i <= 10; i++) send(32'(i), 32'sd0, 5'd0, 1'b0, 1'b1, 8'(i));
    wait_cycles(5);
    check("fill_count", {29'd0, fifo_count}, 32'd4);

    // Push into full FIFO on the same edge as a pop (edge N+3).
    acc_result = 32'sd11;
    acc_finish = 1'b1;
    exp_q.push_back(8'd11);
    tick();
    acc_finish = 1'b0;
    tick();
    tick();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("fullpop_count", {29'd0, fifo_count}, 32'd4);
    check("fullpop_overflow", {31'd0, overflow}, 32'd0);
    bus.out_ready = 1'b1;
    wait_cycles(6);
    check("fullpop_drain_count", {29'd0, fifo_count}, 32'd0);

    // Reset two edges after the capture edge discards the in-flight result.
    acc_result = 32'sd50;
    acc_finish = 1'b1;
    tick();
    acc_finish = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("midrst_count", {29'd0, fifo_count}, 32'd0);
    check("midrst_overflow", {31'd0, overflow}, 32'd0);
    wait_cycles(6);
    check("midrst_no_output", {31'd0, bus.out_valid}, 32'd0);
    check("final_queue_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
